// File: rtl/led_sequencer.sv
// Display scheduler between SW and LEDR: pass-through or timed chase/count/bounce patterns.
// Optional SEQ_SPEED_EN: SW[1:0] divide the animation step rate by 1/2/4/8.
module led_sequencer #(
    parameter int LEDR_SIZE       = 10,
    parameter int TICK_DIV        = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [LEDR_SIZE-1:0] SW,
    output logic [LEDR_SIZE-1:0] LEDR,
    output logic                 tick
);
    localparam int P  = LEDR_SIZE - 2;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_PEN  = PW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_PASS, S_CHASE, S_COUNT, S_BNC_UP, S_BNC_DN
    } state_t;

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [P-1:0]  r_pat;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_dbcnt;
    logic [1:0]    r_req_prev;
    logic          r_tick;

    logic [1:0]    w_req;
    logic          w_stable;
    logic          w_adopt;
    logic          w_wrap;
    logic          w_rate_ok;
    logic          w_tick_next;

    assign w_req    = SW[P+1:P];
    assign w_stable = (w_req == r_req_prev);
    assign w_adopt  = (w_req != r_mode) && w_stable && (r_dbcnt == DB_MAX);
    assign w_wrap   = (r_presc == PRE_LAST);

`ifdef SEQ_SPEED_EN
    logic [2:0] r_wrap;
    logic [1:0] r_rate;
    logic [2:0] w_mask;

    // Tick only on wraps where the low rate bits of the wrap count are all ones.
    assign w_mask    = 3'((4'd1 << r_rate) - 4'd1);
    assign w_rate_ok = ((r_wrap & w_mask) == w_mask);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wrap <= '0;
            r_rate <= '0;
        end else if (w_adopt) begin
            r_wrap <= '0;
            r_rate <= SW[1:0];
        end else if (w_wrap) begin
            r_wrap <= r_wrap + 3'd1;
            r_rate <= SW[1:0];
        end
    end
`else
    assign w_rate_ok = 1'b1;
`endif

    // tick is registered, so it is decided one cycle ahead of the prescaler's last count.
    assign w_tick_next = !w_adopt && (r_state != S_PASS) && (r_presc == PRE_PEN) && w_rate_ok;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_PASS;
            r_mode     <= 2'b00;
            r_pat      <= '0;
            r_presc    <= '0;
            r_dbcnt    <= '0;
            r_req_prev <= 2'b00;
            r_tick     <= 1'b0;
        end else begin
            r_req_prev <= w_req;
            r_tick     <= w_tick_next;
            r_presc    <= (w_adopt || w_wrap) ? '0 : r_presc + PW'(1);

            if ((w_req == r_mode) || !w_stable || w_adopt)
                r_dbcnt <= '0;
            else
                r_dbcnt <= r_dbcnt + DW'(1);

            if (w_adopt) begin
                r_mode <= w_req;
                case (w_req)
                    2'b01: begin
                        r_state <= S_CHASE;
                        r_pat   <= P'(1);
                    end
                    2'b10: begin
                        r_state <= S_COUNT;
                        r_pat   <= SW[P-1:0];
                    end
                    2'b11: begin
                        r_state <= S_BNC_UP;
                        r_pat   <= P'(1);
                    end
                    default: begin
                        r_state <= S_PASS;
                        r_pat   <= SW[P-1:0];
                    end
                endcase
            end else begin
                case (r_state)
                    S_PASS:  r_pat <= SW[P-1:0];
                    S_CHASE: if (r_tick) r_pat <= {r_pat[P-2:0], r_pat[P-1]};
                    S_COUNT: if (r_tick) r_pat <= r_pat + P'(1);
                    S_BNC_UP: begin
                        if (r_tick) begin
                            if (r_pat[P-1]) begin
                                r_pat   <= r_pat >> 1;
                                r_state <= S_BNC_DN;
                            end else begin
                                r_pat   <= r_pat << 1;
                            end
                        end
                    end
                    S_BNC_DN: begin
                        if (r_tick) begin
                            if (r_pat[0]) begin
                                r_pat   <= r_pat << 1;
                                r_state <= S_BNC_UP;
                            end else begin
                                r_pat   <= r_pat >> 1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_PASS;
                        r_mode  <= 2'b00;
                    end
                endcase
            end
        end
    end

    assign LEDR = {r_mode, r_pat};
    assign tick = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_led_sequencer;
    localparam int LS = 10;
    localparam int TD = 4;
    localparam int DB = 3;
`ifdef SEQ_SPEED_EN
    localparam int CNT_GAP = 16;  // COUNT load FE sets SW[1:0]=10 -> every 4th wrap
`else
    localparam int CNT_GAP = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [LS-1:0] sw;
    logic [LS-1:0] ledr;
    logic          tk;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    led_sequencer #(.LEDR_SIZE(LS), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .SW      (sw),
        .LEDR    (ledr),
        .tick    (tk)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles from one observed tick to the next; 200 means no tick arrived.
    task automatic tick_gap(output int gap);
        int n;
        n = 0;
        while (!tk && n < 200) begin
            step(1);
            n++;
        end
        step(1);
        gap = 1;
        while (!tk && gap < 200) begin
            step(1);
            gap++;
        end
    endtask

    initial begin
        logic [7:0] exp_p;
        logic [7:0] cnt_tab [3];
        logic [7:0] bnc_tab [16];
        int         ticks;
        int         gap;
        cnt_tab = '{8'hFF, 8'h00, 8'h01};
        bnc_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // reset with all switches high, then debounce into BOUNCE
        rst = 1'b1;
        sw  = 10'h3FF;
        step(2);
        chk("rst_ledr", 32'(ledr), 32'h000);
        chk("rst_tick", 32'(tk), 32'h0);
        rst = 1'b0;
        step(4);
        chk("db_hold", 32'(ledr), 32'h0FF);
        step(1);
        chk("db_adopt", 32'(ledr), 32'h301);

        // PASS tracking
        rst = 1'b1;
        sw  = 10'h0A5;
        step(1);
        chk("rst2_ledr", 32'(ledr), 32'h000);
        rst = 1'b0;
        step(1);
        chk("pass_a5", 32'(ledr), 32'h0A5);
        sw = 10'h03C;
        step(1);
        chk("pass_3c", 32'(ledr), 32'h03C);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (tk) ticks++;
        end
        chk("pass_noticks", 32'(ticks), 32'd0);

        // CHASE
        sw = 10'h100;
        step(4);
        chk("chase_pre", 32'(ledr), 32'h000);
        step(1);
        chk("chase_load", 32'(ledr), 32'h101);
        exp_p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step(3);
            chk("chase_tick", 32'(tk), 32'h1);
            step(1);
            exp_p = {exp_p[6:0], exp_p[7]};
            chk("chase_pat", 32'(ledr), 32'({2'b01, exp_p}));
        end

        // COUNT from FE, crossing the wrap
        sw = 10'h2FE;
        step(4);
        chk("count_pre", 32'(ledr[9:8]), 32'h1);
        step(1);
        chk("count_load", 32'(ledr), 32'h2FE);
        for (int i = 0; i < 3; i++) begin
            step(CNT_GAP - 1);
            chk("count_tick", 32'(tk), 32'h1);
            step(1);
            chk("count_pat", 32'(ledr), 32'({2'b10, cnt_tab[i]}));
        end

        // BOUNCE
        sw = 10'h300;
        step(4);
        chk("bnc_pre", 32'(ledr[9:8]), 32'h2);
        step(1);
        chk("bnc_load", 32'(ledr), 32'h301);
        for (int i = 0; i < 16; i++) begin
            step(4);
            chk("bnc_pat", 32'(ledr), 32'({2'b11, bnc_tab[i]}));
        end

        // glitching mode request never settles
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 10'h200 : 10'h300;
            step(1);
            chk("toggle_mode", 32'(ledr[9:8]), 32'h3);
        end
        sw = 10'h300;
        step(2);

        // reset mid-bounce
        rst = 1'b1;
        step(1);
        chk("midrst_ledr", 32'(ledr), 32'h000);
        chk("midrst_tick", 32'(tk), 32'h0);
        rst = 1'b0;
        step(1);
        chk("midrst_pass", 32'(ledr), 32'h000);

`ifdef SEQ_SPEED_EN
        rst = 1'b1;
        sw  = 10'h102;
        step(1);
        rst = 1'b0;
        step(5);
        chk("spd_load", 32'(ledr), 32'h101);
        tick_gap(gap);
        chk("spd_gap16", 32'(gap), 32'd16);
        sw = 10'h100;
        tick_gap(gap);
        tick_gap(gap);
        chk("spd_gap4", 32'(gap), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
